lsu_ctrl: RTL and testbench

Load/store controller that consumes the effective address and store data produced by the execute-stage ALU and carries out the data-memory transaction. Generates byte enables and lane-replicated write data, detects misalignment, and performs the memory request/grant/response handshake. Returns sign- or zero-extended load data to writeback. Handles one access at a time, between the ALU and the data-memory port.

---
 rtl/lsu_ctrl_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu_ctrl.sv | 152 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared core types: functional-unit opcodes, LSU FSM states, byte-enable
// patterns and load/store opcode helpers.
package lsu_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned REG_W = 5;

  typedef enum logic [3:0] {
    ADD = 4'h0, SUB = 4'h1, AND = 4'h2, OR  = 4'h3,
    XOR = 4'h4, SLL = 4'h5, SRL = 4'h6, SRA = 4'h7,
    LB  = 4'h8, LH  = 4'h9, LW  = 4'hA, LBU = 4'hB,
    LHU = 4'hC, SB  = 4'hD, SH  = 4'hE, SW  = 4'hF
  } fu_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } lsu_state_e;

  localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
  localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
  localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

  function automatic logic is_ls_op(input fu_op_t op);
    return op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
  endfunction

  function automatic logic is_store(input fu_op_t op);
    return op inside {SB, SH, SW};
  endfunction

  // Byte accesses can never fault.
  function automatic logic is_misaligned(input fu_op_t op, input logic [1:0] off);
    case (op)
      LH, LHU, SH: return off[0];
      LW, SW:      return |off;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and replicated store data for a new
// request, and lane extraction plus sign/zero extension for load responses.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  fu_op_t            i_req_op,
  input  logic [1:0]        i_req_off,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic [BE_W-1:0]   o_be,
  output logic [XLEN-1:0]   o_wdata,
  input  fu_op_t            i_ld_op,
  input  logic [1:0]        i_ld_off,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [XLEN-1:0]   o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = BE_WORD;
    o_wdata = i_req_wdata;
    case (i_req_op)
      LB, LBU, SB: begin
        o_be    = BE_BYTE << i_req_off;
        o_wdata = {4{i_req_wdata[7:0]}};
      end
      LH, LHU, SH: begin
        o_be    = BE_HALF << {i_req_off[1], 1'b0};
        o_wdata = {2{i_req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_byte = 8'(i_rdata >> {i_ld_off, 3'b000});
  assign w_half = 16'(i_rdata >> {i_ld_off[1], 4'b0000});

  always_comb begin
    o_ld_data = i_rdata;
    case (i_ld_op)
      LB:      o_ld_data = {{24{w_byte[7]}}, w_byte};
      LBU:     o_ld_data = {24'h0, w_byte};
      LH:      o_ld_data = {{16{w_half[15]}}, w_half};
      LHU:     o_ld_data = {16'h0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one ALU load/store at a time, runs the
// data-memory req/gnt/rvalid handshake and returns extended load data.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  fu_op_t            req_op_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [REG_W-1:0]  req_rd_i,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic              dmem_we_o,
  output logic [BE_W-1:0]   dmem_be_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              wb_valid_o,
  output logic [REG_W-1:0]  wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic              st_done_o,
  output logic              misaligned_o,
  output logic [XLEN-1:0]   fault_addr_o,
  output logic              busy_o
);

  lsu_state_e         r_state, w_state_n;
  logic               w_accept, w_go, w_fault, w_done;
  logic [BE_W-1:0]    w_be;
  logic [XLEN-1:0]    w_wdata, w_ld_data;

  fu_op_t             r_op;
  logic [1:0]         r_off;
  logic [REG_W-1:0]   r_rd;
  logic               r_we, r_req, r_ready, r_busy;
  logic [BE_W-1:0]    r_be;
  logic [XLEN-1:0]    r_addr, r_wdata;
  logic               r_wb_valid, r_st_done, r_mis;
  logic [REG_W-1:0]   r_wb_rd;
  logic [XLEN-1:0]    r_wb_data, r_fault_addr;

  lsu_align u_align (
    .i_req_op    (req_op_i),
    .i_req_off   (req_addr_i[1:0]),
    .i_req_wdata (req_wdata_i),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .i_ld_op     (r_op),
    .i_ld_off    (r_off),
    .i_rdata     (dmem_rdata_i),
    .o_ld_data   (w_ld_data)
  );

  // Illegal opcodes are dropped; ready is registered and high only in IDLE.
  assign w_accept = req_valid_i && r_ready && is_ls_op(req_op_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_go      = 1'b0;
    w_fault   = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (is_misaligned(req_op_i, req_addr_i[1:0])) begin
            w_fault = 1'b1;
          end else begin
            w_go      = 1'b1;
            w_state_n = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) w_state_n = WAIT_R;
      end
      WAIT_R: begin
        if (dmem_rvalid_i) begin
          w_done    = 1'b1;
          w_state_n = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Request fields are latched on accept and drive the memory port directly.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_op         <= ADD;
      r_off        <= 2'b00;
      r_rd         <= '0;
      r_we         <= 1'b0;
      r_be         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_req        <= 1'b0;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_st_done    <= 1'b0;
      r_mis        <= 1'b0;
      r_fault_addr <= '0;
    end else begin
      if (w_go) begin
        r_op    <= req_op_i;
        r_off   <= req_addr_i[1:0];
        r_rd    <= req_rd_i;
        r_we    <= is_store(req_op_i);
        r_be    <= w_be;
        r_addr  <= {req_addr_i[XLEN-1:2], 2'b00};
        r_wdata <= w_wdata;
      end
      r_req      <= (w_state_n == REQ);
      r_ready    <= (w_state_n == IDLE);
      r_busy     <= (w_state_n != IDLE);
      r_wb_valid <= w_done && !r_we;
      r_st_done  <= w_done && r_we;
      if (w_done && !r_we) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= w_ld_data;
      end
      r_mis <= w_fault;
      if (w_fault) r_fault_addr <= req_addr_i;
    end
  end

  assign req_ready_o  = r_ready;
  assign busy_o       = r_busy;
  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_be_o    = r_be;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;
  assign wb_valid_o   = r_wb_valid;
  assign wb_rd_o      = r_wb_rd;
  assign wb_data_o    = r_wb_data;
  assign st_done_o    = r_st_done;
  assign misaligned_o = r_mis;
  assign fault_addr_o = r_fault_addr;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: inputs driven and outputs sampled on the
// falling clock edge, expected values hand-computed.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  fu_op_t      req_op_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        dmem_req_o, dmem_gnt_i, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        st_done_o, misaligned_o, busy_o;
  logic [31:0] fault_addr_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  lsu_ctrl dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_rd_i      (req_rd_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_we_o     (dmem_we_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .wb_valid_o    (wb_valid_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .st_done_o     (st_done_o),
    .misaligned_o  (misaligned_o),
    .fault_addr_o  (fault_addr_o),
    .busy_o        (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ready"}, req_ready_o, 1);
    chk({tag, " busy"},  busy_o,      0);
    chk({tag, " req"},   dmem_req_o,  0);
  endtask

  // Accept at N, gnt at N+1, rvalid at N+2; returns at N+3 with results checked.
  task automatic do_access(input string tag, input fu_op_t op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd,
                           input logic [31:0] rdata, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input logic is_st,
                           input logic [31:0] exp_ld);
    req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr;
    req_wdata_i = wd;   req_rd_i = rd;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk({tag, " dmem_req"},  dmem_req_o,  1);
    chk({tag, " dmem_addr"}, dmem_addr_o, addr & 32'hFFFF_FFFC);
    chk({tag, " dmem_be"},   dmem_be_o,   exp_be);
    chk({tag, " dmem_we"},   dmem_we_o,   is_st);
    chk({tag, " busy"},      busy_o,      1);
    chk({tag, " ready"},     req_ready_o, 0);
    if (is_st) chk({tag, " dmem_wdata"}, dmem_wdata_o, exp_wd);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    chk({tag, " req_drop"}, dmem_req_o, 0);
    chk({tag, " no_wb"},    wb_valid_o, 0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    chk({tag, " wb_valid"}, wb_valid_o,  !is_st);
    chk({tag, " st_done"},  st_done_o,   is_st);
    chk({tag, " ready"},    req_ready_o, 1);
    if (!is_st) begin
      chk({tag, " wb_data"}, wb_data_o, exp_ld);
      chk({tag, " wb_rd"},   wb_rd_o,   rd);
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_op_i = ADD; req_addr_i = '0;
    req_wdata_i = '0; req_rd_i = '0; dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    repeat (2) @(negedge clk_i);

    // Reset values
    chk_idle("rst");
    chk("rst wb_valid", wb_valid_o,   0);
    chk("rst st_done",  st_done_o,    0);
    chk("rst mis",      misaligned_o, 0);
    chk("rst fault",    fault_addr_o, 0);
    chk("rst addr",     dmem_addr_o,  0);
    chk("rst be",       dmem_be_o,    0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Loads; each back-to-back call accepts in the cycle of the previous wb pulse
    do_access("LW",  LW,  32'h1000, 32'h0, 5'd5,  32'hDEADBEEF, 4'b1111, 32'h0, 0, 32'hDEADBEEF);
    do_access("LB",  LB,  32'h1003, 32'h0, 5'd6,  32'h80FF0000, 4'b1000, 32'h0, 0, 32'hFFFFFF80);
    do_access("LBU", LBU, 32'h1003, 32'h0, 5'd7,  32'h80FF0000, 4'b1000, 32'h0, 0, 32'h00000080);
    do_access("LB2", LB,  32'h1001, 32'h0, 5'd8,  32'h80FF7F00, 4'b0010, 32'h0, 0, 32'h0000007F);
    do_access("LH",  LH,  32'h1002, 32'h0, 5'd9,  32'h80FF0000, 4'b1100, 32'h0, 0, 32'hFFFF80FF);
    do_access("LHU", LHU, 32'h1002, 32'h0, 5'd10, 32'h80FF0000, 4'b1100, 32'h0, 0, 32'h000080FF);

    // Stores
    do_access("SH", SH, 32'h2002, 32'h00001234, 5'd1, 32'h0, 4'b1100, 32'h12341234, 1, 32'h0);
    do_access("SB", SB, 32'h2001, 32'h000000AB, 5'd1, 32'h0, 4'b0010, 32'hABABABAB, 1, 32'h0);
    do_access("SW", SW, 32'h2004, 32'hCAFEF00D, 5'd1, 32'h0, 4'b1111, 32'hCAFEF00D, 1, 32'h0);
    @(negedge clk_i);
    chk("st_done pulse", st_done_o, 0);

    // Misaligned LW, then a misaligned SH accepted the very next cycle
    req_valid_i = 1'b1; req_op_i = LW; req_addr_i = 32'h1002;
    @(negedge clk_i);
    chk("mis1 flag",  misaligned_o, 1);
    chk("mis1 addr",  fault_addr_o, 32'h1002);
    chk_idle("mis1");
    req_op_i = SH; req_addr_i = 32'h3001;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("mis2 flag",  misaligned_o, 1);
    chk("mis2 addr",  fault_addr_o, 32'h3001);
    chk_idle("mis2");
    @(negedge clk_i);
    chk("mis pulse", misaligned_o, 0);

    // Illegal opcode is not accepted
    req_valid_i = 1'b1; req_op_i = ADD; req_addr_i = 32'h1003;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk_idle("illegal");
    chk("illegal mis", misaligned_o, 0);

    // Stray rvalid in IDLE
    dmem_rvalid_i = 1'b1;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    chk("stray idle wb", wb_valid_o, 0);
    chk("stray idle st", st_done_o,  0);

    // Grant held off 5 cycles with a stray rvalid during REQ
    req_valid_i = 1'b1; req_op_i = LW; req_addr_i = 32'h4008; req_rd_i = 5'd7;
    @(negedge clk_i);
    req_valid_i = 1'b0; req_addr_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("hold req",  dmem_req_o,  1);
      chk("hold addr", dmem_addr_o, 32'h4008);
      chk("hold be",   dmem_be_o,   4'b1111);
      chk("hold wb",   wb_valid_o,  0);
      dmem_rvalid_i = (i == 2);
      dmem_rdata_i  = 32'hBAD0BAD0;
      @(negedge clk_i);
    end
    dmem_rvalid_i = 1'b0;
    chk("hold req5", dmem_req_o, 1);
    dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    chk("hold drop", dmem_req_o, 0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h11223344;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    chk("hold wb_valid", wb_valid_o, 1);
    chk("hold wb_data",  wb_data_o,  32'h11223344);
    chk("hold wb_rd",    wb_rd_o,    5'd7);

    // Reset while in WAIT_R, then a late response
    req_valid_i = 1'b1; req_op_i = LW; req_addr_i = 32'h5000; req_rd_i = 5'd9;
    @(negedge clk_i);
    req_valid_i = 1'b0; dmem_gnt_i = 1'b1;
    @(negedge clk_i);
    dmem_gnt_i = 1'b0;
    chk("wr busy", busy_o, 1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk_idle("rst_mid");
    chk("rst_mid wb",    wb_valid_o, 0);
    chk("rst_mid wbdat", wb_data_o,  0);
    rst_ni = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h55AA55AA;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    chk("late wb",    wb_valid_o, 0);
    chk("late st",    st_done_o,  0);
    chk_idle("late");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
